// File: rtl/uart_frame_pkg.sv
// Shared types and helpers for the UART frame scheduler: FSM states,
// the default header byte and a frame-length helper.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_HDR  = 3'd1,
        START_BYTE = 3'd2,
        WAIT       = 3'd3,
        CHECKSUM   = 3'd4,
        DONE       = 3'd5
    } frame_state_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Bytes per frame: header, WIDTH/8 data bytes, optional checksum byte.
    function automatic int frame_len(input int width, input bit csum);
        return 1 + width / 8 + (csum ? 1 : 0);
    endfunction

endpackage

// File: rtl/uart_frame_scheduler.sv
// Streams a captured WIDTH-bit snapshot to a byte transmitter as one frame:
// header, then data bytes LSB first. Define UART_FRAME_CHECKSUM_EN to append an XOR checksum byte.
module uart_frame_scheduler
    import uart_frame_pkg::*;
#(
    parameter int         WIDTH  = 512,
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_snap,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_tx_start,
    output logic [7:0]       o_tx_data,
    input  logic             i_tx_done,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_overrun
);

    localparam int NBYTES = WIDTH / 8;
    localparam int IDX_W  = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES);

    frame_state_t              state_reg, state_next;
    logic [NBYTES-1:0][7:0]    shadow_reg;
    logic [IDX_W-1:0]          index_reg;
    logic [7:0]                tx_data_reg;
    logic                      pending_reg;
    logic                      overrun_reg;

    logic capture;
    logic load_byte;
    logic load_csum;

`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0] csum_reg;
    logic       csum_sent_reg;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        o_tx_start   = 1'b0;
        o_frame_done = 1'b0;
        capture      = 1'b0;
        load_byte    = 1'b0;
        load_csum    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_snap) begin
                    capture    = 1'b1;
                    state_next = START_HDR;
                end
            end
            START_HDR, START_BYTE, CHECKSUM: begin
                o_tx_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (index_reg != LAST_IDX) begin
                        load_byte  = 1'b1;
                        state_next = START_BYTE;
                    end else begin
`ifdef UART_FRAME_CHECKSUM_EN
                        if (!csum_sent_reg) begin
                            load_csum  = 1'b1;
                            state_next = CHECKSUM;
                        end else begin
                            state_next = DONE;
                        end
`else
                        state_next = DONE;
`endif
                    end
                end
            end
            DONE: begin
                o_frame_done = 1'b1;
                // A request landing in DONE counts as pending so the next frame follows directly.
                if (pending_reg || i_snap) begin
                    capture    = 1'b1;
                    state_next = START_HDR;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_reg  <= '0;
            index_reg   <= '0;
            tx_data_reg <= 8'h00;
        end else begin
            if (capture) begin
                shadow_reg  <= i_data;
                index_reg   <= '0;
                tx_data_reg <= HEADER;
            end
            if (load_byte) begin
                tx_data_reg <= shadow_reg[index_reg];
            end
            if (state_reg == START_BYTE) begin
                index_reg <= index_reg + 1'b1;
            end
`ifdef UART_FRAME_CHECKSUM_EN
            if (load_csum) begin
                tx_data_reg <= csum_reg;
            end
`endif
        end
    end

`ifdef UART_FRAME_CHECKSUM_EN
    // The byte on the wire during START_BYTE is exactly the data byte to fold in.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            csum_reg      <= 8'h00;
            csum_sent_reg <= 1'b0;
        end else begin
            if (capture) begin
                csum_reg      <= 8'h00;
                csum_sent_reg <= 1'b0;
            end else begin
                if (state_reg == START_BYTE) begin
                    csum_reg <= csum_reg ^ tx_data_reg;
                end
                if (state_reg == CHECKSUM) begin
                    csum_sent_reg <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_load_csum;
    assign unused_load_csum = load_csum;
`endif

    // One request may queue behind the frame in flight; any further one is dropped and flagged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (state_reg == DONE) begin
            pending_reg <= 1'b0;
            if (i_snap && pending_reg) begin
                overrun_reg <= 1'b1;
            end
        end else if (i_snap && state_reg != IDLE) begin
            if (pending_reg) begin
                overrun_reg <= 1'b1;
            end else begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign o_tx_data = tx_data_reg;
    assign o_busy    = (state_reg != IDLE);
    assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Scoreboard bench for uart_frame_scheduler at WIDTH=16 with a 10-cycle transmitter model.
module tb_uart_frame_scheduler;
    import uart_frame_pkg::*;

    localparam int WIDTH = 16;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int FLEN = frame_len(WIDTH, CSUM);

    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_snap = 1'b0;
    logic [WIDTH-1:0] i_data = '0;
    logic             o_tx_start;
    logic [7:0]       o_tx_data;
    logic             i_tx_done;
    logic             o_busy;
    logic             o_frame_done;
    logic             o_overrun;

    logic model_done = 1'b0;
    logic spur_done = 1'b0;
    assign i_tx_done = model_done | spur_done;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int fd_cnt = 0;
    int cd = 0;
    logic [7:0] held = 8'h00;
    logic last_done = 1'b0;
    logic [7:0] exp_q[$];

    uart_frame_scheduler #(.WIDTH(WIDTH), .HEADER(8'hA5)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_snap(i_snap), .i_data(i_data),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    // Transmitter model and byte monitor, sampled mid-cycle.
    always @(negedge clk) begin
        last_done  = model_done;
        model_done = 1'b0;
        if (i_rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd = cd - 1;
                checks++;
                if (o_tx_data !== held) begin
                    errors++;
                    $display("FAIL data_stable got %02h want %02h", o_tx_data, held);
                end
                if (cd == 0) model_done = 1'b1;
            end
            if (o_tx_start) begin
                start_cnt++;
                held = o_tx_data;
                cd = 10;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_start got byte %02h want no start", o_tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (o_tx_data !== e) begin
                        errors++;
                        $display("FAIL tx_byte got %02h want %02h", o_tx_data, e);
                    end
                end
                $display("byte %02h (start #%0d)", o_tx_data, start_cnt);
            end
            if (o_frame_done) begin
                fd_cnt++;
                checks++;
                if (!last_done) begin
                    errors++;
                    $display("FAIL frame_done_timing got no done in previous cycle want done");
                end
            end
        end
    end

    task automatic push_frame(input logic [WIDTH-1:0] d);
        logic [7:0] c;
        c = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < WIDTH / 8; k++) begin
            exp_q.push_back(d[8*k +: 8]);
            c = c ^ d[8*k +: 8];
        end
        if (CSUM) exp_q.push_back(c);
    endtask

    task automatic pulse_snap();
        @(negedge clk);
        i_snap = 1'b1;
        @(negedge clk);
        i_snap = 1'b0;
    endtask

    task automatic wait_frame_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (o_frame_done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout got no frame_done want frame_done within 300 cycles", name);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d bytes outstanding want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_tx_start, o_tx_data, o_busy, o_frame_done, o_overrun} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got start=%b data=%02h busy=%b fd=%b ovr=%b want all 0",
                     o_tx_start, o_tx_data, o_busy, o_frame_done, o_overrun);
        end
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_single_frame();
        int s0;
        s0 = start_cnt;
        i_data = 16'h1234;
        push_frame(16'h1234);
        @(negedge clk);
        i_snap = 1'b1;
        @(negedge clk);
        i_snap = 1'b0;
        checks++;
        if (o_tx_start !== 1'b1 || o_busy !== 1'b1 || o_tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL header_latency got start=%b busy=%b data=%02h want 1 1 a5",
                     o_tx_start, o_busy, o_tx_data);
        end
        wait_frame_done("single");
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall got busy=%b fd=%b want 0 0", o_busy, o_frame_done);
        end
        checks++;
        if (start_cnt - s0 != FLEN) begin
            errors++;
            $display("FAIL single_len got %0d want %0d", start_cnt - s0, FLEN);
        end
        check_drained("single");
        $display("single frame done");
    endtask

    task automatic test_back_to_back();
        i_data = 16'h1234;
        push_frame(16'h1234);
        push_frame(16'hBEEF);
        pulse_snap();
        i_data = 16'hBEEF;
        repeat (5) @(negedge clk);
        pulse_snap();
        wait_frame_done("b2b_first");
        @(negedge clk);
        checks++;
        if (o_tx_start !== 1'b1 || o_busy !== 1'b1 || o_tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL b2b_restart got start=%b busy=%b data=%02h want 1 1 a5",
                     o_tx_start, o_busy, o_tx_data);
        end
        i_data = 16'h0000;
        wait_frame_done("b2b_second");
        @(negedge clk);
        checks++;
        if (o_overrun !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun got ovr=%b busy=%b want 0 0", o_overrun, o_busy);
        end
        check_drained("b2b");
        $display("back-to-back done");
    endtask

    task automatic test_overrun();
        int s0;
        s0 = start_cnt;
        i_data = 16'h5A3C;
        push_frame(16'h5A3C);
        push_frame(16'h5A3C);
        pulse_snap();
        repeat (3) @(negedge clk);
        pulse_snap();
        checks++;
        if (o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_early got %b want 0", o_overrun);
        end
        repeat (3) @(negedge clk);
        pulse_snap();
        checks++;
        if (o_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got %b want 1", o_overrun);
        end
        wait_frame_done("ovr_first");
        wait_frame_done("ovr_second");
        repeat (40) @(negedge clk);
        checks++;
        if (start_cnt - s0 != 2 * FLEN || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_frames got %0d starts busy=%b want %0d starts busy=0",
                     start_cnt - s0, o_busy, 2 * FLEN);
        end
        checks++;
        if (o_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky got %b want 1", o_overrun);
        end
        check_drained("overrun");
        $display("overrun done");
    endtask

    task automatic test_reset_mid_frame();
        int s0;
        bit seen;
        s0 = start_cnt;
        seen = 1'b0;
        i_data = 16'hC0DE;
        push_frame(16'hC0DE);
        pulse_snap();
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (start_cnt - s0 >= 2) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_reach_byte1 got %0d starts want 2", start_cnt - s0);
        end
        repeat (3) @(negedge clk);
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if ({o_tx_start, o_tx_data, o_busy, o_frame_done, o_overrun} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset got start=%b data=%02h busy=%b fd=%b ovr=%b want all 0",
                     o_tx_start, o_tx_data, o_busy, o_frame_done, o_overrun);
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        s0 = start_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (start_cnt != s0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet got %0d starts busy=%b want 0 starts busy=0",
                     start_cnt - s0, o_busy);
        end
        i_data = 16'h7E81;
        push_frame(16'h7E81);
        pulse_snap();
        wait_frame_done("post_reset");
        checks++;
        if (start_cnt - s0 != FLEN) begin
            errors++;
            $display("FAIL post_reset_len got %0d want %0d", start_cnt - s0, FLEN);
        end
        check_drained("post_reset");
        $display("reset mid-frame done");
    endtask

    task automatic test_spurious_done();
        int s0;
        s0 = start_cnt;
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || start_cnt != s0) begin
            errors++;
            $display("FAIL spurious_idle got busy=%b starts=%0d want busy=0 starts=0",
                     o_busy, start_cnt - s0);
        end
        i_data = 16'h0F96;
        push_frame(16'h0F96);
        @(negedge clk);
        i_snap = 1'b1;
        @(negedge clk);
        i_snap = 1'b0;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        // Also hit the first data byte's start pulse.
        for (int i = 0; i < 40 && !o_tx_start; i++) @(negedge clk);
        spur_done = o_tx_start;
        @(negedge clk);
        spur_done = 1'b0;
        wait_frame_done("spurious");
        checks++;
        if (start_cnt - s0 != FLEN) begin
            errors++;
            $display("FAIL spurious_len got %0d want %0d", start_cnt - s0, FLEN);
        end
        check_drained("spurious");
        $display("spurious done checked");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_spurious_done();
        test_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
